// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
//   tx_state_e   : transmitter FSM states
//   parity_e     : line parity encodings as presented on parity_mode_i
//   MIN_BAUD_DIV : smallest usable baud divider; smaller values select the default
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    ParityNone = 2'b00,
    ParityEven = 2'b01,
    ParityOdd  = 2'b10
  } parity_e;

  localparam logic [15:0] MIN_BAUD_DIV = 16'd2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered status flags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wen, wdata    : write strobe and data; ignored while full
//   ren, rdata    : pop strobe; rdata always shows the head word
//   full, empty   : registered status
//   level         : registered occupancy, one bit wider than the pointers
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] FullLevel = (AddrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   level_q, level_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  // Gate on the registered flags so a same-cycle pop never frees room for a write.
  assign do_wr = wen & ~full_q;
  assign do_rd = ren & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == FullLevel);
      empty_q <= (level_d == '0);
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with integrated TX FIFO and per-frame line configuration.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   baud_div_i        : clock cycles per bit; values below 2 select BAUD_DIV_RST
//   parity_mode_i     : 00 none, 01 even, 10 odd, 11 none
//   stop2_i           : two stop bits when high
//   tx_en_i           : allows new frames to start
//   tx_wen_i, din_i   : FIFO write strobe and data
//   full_o, empty_o,
//   level_o           : registered FIFO status
//   wr_drop_o         : one-cycle pulse after a write was rejected (FIFO full)
//   busy_o            : a frame is on the line
//   tx_bit_o          : serial output, idles high
// Line outputs are registered from the FSM state, so they trail the state by one cycle.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned BAUD_DIV_RST = 104
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   baud_div_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop2_i,
  input  logic                          tx_en_i,
  input  logic                          tx_wen_i,
  input  logic [DATA_W-1:0]             din_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          wr_drop_o,
  output logic                          busy_o,
  output logic                          tx_bit_o
);

  localparam int unsigned BitCntW = $clog2(DATA_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  logic [DATA_W-1:0]  fifo_rdata;
  logic               pop;

  tx_state_e          state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        div_q, div_d;
  logic [BitCntW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               stop2_q, stop2_d;
  logic               stop_hi_q, stop_hi_d;
  logic               tx_q, tx_d;
  logic               busy_q;
  logic               wr_drop_q;

  logic [15:0]        div_eff;
  logic               start_ok;
  logic               bit_end;
  logic               load;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wen    (tx_wen_i),
    .ren    (pop),
    .wdata  (din_i),
    .rdata  (fifo_rdata),
    .full   (full_o),
    .empty  (empty_o),
    .level  (level_o)
  );

  assign div_eff  = (baud_div_i < MIN_BAUD_DIV) ? 16'(BAUD_DIV_RST) : baud_div_i;
  assign start_ok = tx_en_i & ~empty_o;
  assign bit_end  = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_hi_d = stop_hi_q;
    load      = 1'b0;
    pop       = 1'b0;

    if (state_q != StIdle && !bit_end) cnt_d = cnt_q - 16'd1;

    case (state_q)
      StIdle: begin
        if (start_ok) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = div_q - 16'd1;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = div_q - 16'd1;
          if (bit_q == LastBit) begin
            state_d   = par_en_q ? StParity : StStop;
            stop_hi_d = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          cnt_d     = div_q - 16'd1;
          stop_hi_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_hi_q) begin
            stop_hi_d = 1'b1;
            cnt_d     = div_q - 16'd1;
          end else if (start_ok) begin
            // Chain straight into the next start bit; no idle bit between frames.
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start: pop the head word and freeze the line configuration.
    if (load) begin
      pop       = 1'b1;
      state_d   = StStart;
      div_d     = div_eff;
      cnt_d     = div_eff - 16'd1;
      shift_d   = fifo_rdata;
      par_en_d  = (parity_mode_i == ParityEven) || (parity_mode_i == ParityOdd);
      par_bit_d = (^fifo_rdata) ^ (parity_mode_i == ParityOdd);
      stop2_d   = stop2_i;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      tx_q      <= tx_d;
      busy_q    <= (state_q != StIdle);
      wr_drop_q <= tx_wen_i & full_o;
    end
  end

  assign tx_bit_o  = tx_q;
  assign busy_o    = busy_q;
  assign wr_drop_o = wr_drop_q;

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It generalises the team's fixed 8N1 TX interface in three ways: configurable data width, configurable FIFO depth, and runtime-selectable parity and stop-bit count. It sits between a bus/testbench master that pushes bytes through the `master` modport signals and the serial `tx_bit_o` pin. Line configuration is sampled once per frame, so reconfiguration never corrupts a frame in flight.

Parameters:
- DATA_W, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16: TX FIFO entries; must be a power of two, at least 2.
- BAUD_DIV_RST, 104: documented default for `baud_div_i`; the block uses it only when `baud_div_i` is below 2.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: asynchronous active-low reset.
- baud_div_i, input, 16: clock cycles per bit period.
- parity_mode_i, input, 2: 00 = none, 01 = even, 10 = odd, 11 = treated as none.
- stop2_i, input, 1: 1 = two stop bits, 0 = one stop bit.
- tx_en_i, input, 1: enables the start of new frames.
- tx_wen_i, input, 1: FIFO write strobe.
- din_i, input, DATA_W: write data.
- full_o, output, 1: FIFO full.
- empty_o, output, 1: FIFO empty.
- level_o, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- wr_drop_o, output, 1: one-cycle pulse when a write is rejected.
- busy_o, output, 1: a frame is in progress.
- tx_bit_o, output, 1: serial output; idles high.

Behaviour:
- Reset (async assert, sync release):
  - FIFO flushed; `level_o` = 0, `empty_o` = 1, `full_o` = 0.
  - `wr_drop_o` = 0, `busy_o` = 0, `tx_bit_o` = 1, FSM in IDLE.
  - Reset mid-frame forces `tx_bit_o` high immediately and discards the frame.
- Write:
  - Accepted on a clock edge when `tx_wen_i` = 1 and the registered `full_o` = 0.
  - If `tx_wen_i` = 1 while `full_o` = 1, the data is discarded and `wr_drop_o` pulses on the next cycle.
  - A pop on the same cycle does not make room for a write issued while full.
- Flags: `full_o`, `empty_o` and `level_o` are registered. They update on the cycle after a write or pop. A simultaneous write and pop leaves `level_o` unchanged.
- Effective divider: `div` = `baud_div_i` if `baud_div_i` ≥ 2, otherwise BAUD_DIV_RST. It is latched with `parity_mode_i` and `stop2_i` at frame start.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `tx_en_i` = 1 and `empty_o` = 0, pop the head word, latch word and config, and go to START.
  - START: `tx_bit_o` = 0 for `div` cycles.
  - DATA: DATA_W bits, LSB first, `div` cycles each.
  - PARITY: entered only if the latched mode is 01 or 10. Even mode sends the XOR of the data bits; odd mode sends its inverse. Lasts `div` cycles.
  - STOP: `tx_bit_o` = 1 for `div` cycles, or 2×`div` cycles if `stop2_i` was latched high.
  - After STOP, return to IDLE. If the start conditions hold on that cycle, the next frame begins back-to-back with no extra idle bit.
- Bit timing: a down-counter reloads to `div`−1 on each bit entry; the bit ends when the counter reaches 0.
- Latency: a write to an empty FIFO while IDLE and enabled produces the falling edge of `tx_bit_o` on the second rising edge after the write edge. `busy_o` rises on the same cycle as that falling edge.
- `busy_o` = 1 in every state except IDLE.
- Dropping `tx_en_i` mid-frame lets the current frame finish; no new frame starts.
- Config inputs changing mid-frame have no effect until the next frame.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is one bit wider than the pointers, so full and empty are distinguished.

Decomposition:
- Package `uart_pkg`:
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - `parity_e` enum (NONE = 2'b00, EVEN = 2'b01, ODD = 2'b10).
  - Constant MIN_BAUD_DIV = 2.
- Sub-module `sync_fifo`, parametrised by WIDTH and DEPTH:
  - Ports: `clk_i`, `rst_ni`, `wen`, `ren`, `wdata`, `rdata`, `full`, `empty`, `level`.
  - Read is first-word-fall-through.
- The top level holds the FSM, baud counter, bit counter and shift register.

Test Plan:
- 8N1, `baud_div_i` = 4, write 0x55 → `tx_bit_o` sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; `busy_o` high for 40 cycles; falling edge 2 cycles after the write.
- Odd parity, 2 stop bits, `div` = 8, write 0xA3 (four ones) → parity bit = 1, then stop high for 16 cycles; frame lasts 12×8 = 96 cycles.
- `tx_en_i` = 0, write 17 words to a 16-deep FIFO → `full_o` = 1, `level_o` = 16, one `wr_drop_o` pulse. Then `tx_en_i` = 1 → 16 back-to-back frames in order; the 17th word is never sent.
- `baud_div_i` changed from 4 to 8 mid-frame → the current frame stays at 4 cycles per bit and the next frame uses 8; `baud_div_i` = 0 → 104 cycles per bit.
- `rst_ni` pulsed low during DATA with 3 words queued → `tx_bit_o` goes to 1 asynchronously; `empty_o` = 1 and `busy_o` = 0 after reset; no further frames.
- Instance with DATA_W = 7, even parity, write 7'h7F → 7 data ones followed by parity 1; simultaneous write and pop at `level_o` = 1 keeps `level_o` = 1.
